pipe_ctrl: RTL and testbench

Pipeline stall/flush scheduler for the five-stage MIPS core. It drives the write-enable and clear controls of the F/D/E/M/W pipeline registers. It owns the multi-cycle multiply/divide busy countdown and selects the next-PC source on exception entry and `eret`. It sits beside the datapath, taking hazard and exception status from D, E and M and returning per-stage control in the same cycle.

---
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline stall/flush scheduler for the five-stage MIPS core.
//
// Generates the write-enable and clear controls of the F/D/E/M/W pipeline
// registers, owns the multiply/divide busy countdown and picks the next-PC
// source on exception entry and eret.
//
// Parameters:
//   MULT_CYCLES   busy cycles loaded for mult/multu (1..15)
//   DIV_CYCLES    busy cycles loaded for div/divu   (1..15)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   hazard_stall   D-stage data hazard requires a stall
//   E_md_start     E-stage instruction is mult/multu/div/divu
//   E_md_div       qualifies E_md_start: 1 = div type, 0 = mult type
//   D_md_use       D-stage instruction uses the MDU
//   exc_req        M stage takes an exception/interrupt this cycle
//   eret_M         eret is in M this cycle
//   F_WE..W_WE     pipeline-register write enables (combinational)
//   D_clr..M_clr   bubble inserts into D/E/M registers (combinational)
//   pc_sel         00 PC+4/branch, 01 handler, 10 EPC (combinational)
//   md_busy        MDU countdown active (registered)
//   md_count       remaining MDU busy cycles (registered)
//   stall_cycles   32-bit stall counter, only with PIPE_CTRL_STALL_CNT_EN
//
// Optional feature macro: PIPE_CTRL_STALL_CNT_EN adds the stall_cycles port
// and its counter; without it the block is otherwise identical.

module pipe_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hazard_stall,
  input  logic       E_md_start,
  input  logic       E_md_div,
  input  logic       D_md_use,
  input  logic       exc_req,
  input  logic       eret_M,
  output logic       F_WE,
  output logic       D_WE,
  output logic       E_WE,
  output logic       M_WE,
  output logic       W_WE,
  output logic       D_clr,
  output logic       E_clr,
  output logic       M_clr,
  output logic [1:0] pc_sel,
  output logic       md_busy,
  output logic [3:0] md_count
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_MDBUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_EXC  = 2'b01;
  localparam logic [1:0] PC_EPC  = 2'b10;

  logic [0:0] state_q, state_d;
  logic [3:0] md_count_q, md_count_d;
  logic       start_ok;
  logic       stall;

  // An exception in M squashes the instruction in E, so its start is dropped.
  assign start_ok = E_md_start & ~exc_req;

  // A start in E already occupies the MDU for the instruction in D, so it
  // stalls in the same cycle even though md_busy only rises next cycle.
  assign stall = hazard_stall | (D_md_use & (md_busy | E_md_start));

  always_comb begin
    md_count_d = md_count_q;
    state_d    = state_q;
    if (start_ok) begin
      md_count_d = E_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (state_q == ST_MDBUSY) begin
      md_count_d = md_count_q - 4'd1;
    end
    state_d = (md_count_d != 4'd0) ? ST_MDBUSY : ST_RUN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      md_count_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      md_count_q <= md_count_d;
    end
  end

  assign md_count = md_count_q;
  assign md_busy  = (md_count_q != 4'd0);

  // Priority: exception, then eret, then stall, then normal flow.
  always_comb begin
    F_WE   = 1'b1;
    D_WE   = 1'b1;
    E_WE   = 1'b1;
    M_WE   = 1'b1;
    W_WE   = 1'b1;
    D_clr  = 1'b0;
    E_clr  = 1'b0;
    M_clr  = 1'b0;
    pc_sel = PC_SEQ;
    if (exc_req) begin
      D_clr  = 1'b1;
      E_clr  = 1'b1;
      M_clr  = 1'b1;
      pc_sel = PC_EXC;
    end else if (eret_M) begin
      D_clr  = 1'b1;
      E_clr  = 1'b1;
      pc_sel = PC_EPC;
    end else if (stall) begin
      F_WE  = 1'b0;
      D_WE  = 1'b0;
      E_clr = 1'b1;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles_q;

  // Counts only stalls that actually hold F/D; flush cycles override stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
    end else if (stall && !exc_req && !eret_M) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
//
// A table of {inputs, expected outputs} records is applied one per cycle,
// followed by hand-written multi-cycle sequences (mult/mfhi stall, reload,
// exception during a div countdown, asynchronous reset mid-count).
// Expected records go into a queue when stimulus is driven and are popped
// and compared when the outputs are sampled away from the rising edge.

module tb_pipe_ctrl;

  typedef struct {
    string      nm;
    logic       hs;
    logic       st;
    logic       dv;
    logic       mdUse;
    logic       exc;
    logic       eret;
    logic [4:0] we;    // {F,D,E,M,W}
    logic [2:0] clr;   // {D,E,M}
    logic [1:0] pc;
    logic [3:0] cnt;
  } vec_t;

  localparam logic [4:0] WE_ALL    = 5'b11111;
  localparam logic [4:0] WE_STALL  = 5'b00111;
  localparam logic [2:0] CLR_NONE  = 3'b000;
  localparam logic [2:0] CLR_STALL = 3'b010;
  localparam logic [2:0] CLR_ERET  = 3'b110;
  localparam logic [2:0] CLR_EXC   = 3'b111;

  logic       clk;
  logic       reset;
  logic       hazard_stall;
  logic       E_md_start;
  logic       E_md_div;
  logic       D_md_use;
  logic       exc_req;
  logic       eret_M;
  logic       F_WE, D_WE, E_WE, M_WE, W_WE;
  logic       D_clr, E_clr, M_clr;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic [3:0] md_count;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
  int unsigned expStall;
`endif

  int compared;
  int mismatched;
  vec_t expQ[$];
  vec_t tbl[16];

  pipe_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hazard_stall(hazard_stall),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .D_md_use    (D_md_use),
    .exc_req     (exc_req),
    .eret_M      (eret_M),
    .F_WE        (F_WE),
    .D_WE        (D_WE),
    .E_WE        (E_WE),
    .M_WE        (M_WE),
    .W_WE        (W_WE),
    .D_clr       (D_clr),
    .E_clr       (E_clr),
    .M_clr       (M_clr),
    .pc_sel      (pc_sel),
    .md_busy     (md_busy),
    .md_count    (md_count)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(string nm, logic hs, logic st, logic dv,
                                 logic mdUse, logic exc, logic eret,
                                 logic [4:0] we, logic [2:0] clr,
                                 logic [1:0] pc, logic [3:0] cnt);
    vec_t v;
    v.nm = nm; v.hs = hs; v.st = st; v.dv = dv; v.mdUse = mdUse;
    v.exc = exc; v.eret = eret; v.we = we; v.clr = clr; v.pc = pc;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic cmp(string what, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", what, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    hazard_stall = v.hs;
    E_md_start   = v.st;
    E_md_div     = v.dv;
    D_md_use     = v.mdUse;
    exc_req      = v.exc;
    eret_M       = v.eret;
    expQ.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a record");
      return;
    end
    e = expQ.pop_front();
    cmp({e.nm, " we"},  int'({F_WE, D_WE, E_WE, M_WE, W_WE}), int'(e.we));
    cmp({e.nm, " clr"}, int'({D_clr, E_clr, M_clr}), int'(e.clr));
    cmp({e.nm, " pc_sel"}, int'(pc_sel), int'(e.pc));
    cmp({e.nm, " md_count"}, int'(md_count), int'(e.cnt));
    cmp({e.nm, " md_busy"}, int'(md_busy), (e.cnt != 4'd0) ? 1 : 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    cmp({e.nm, " stall_cycles"}, int'(stall_cycles), int'(expStall));
`endif
  endtask

  // One full cycle: drive after the edge, sample at the falling edge.
  task automatic runCycle(vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
`ifdef PIPE_CTRL_STALL_CNT_EN
    if (reset && v.we[4] == 1'b0) expStall++;
`endif
    #1;
  endtask

  initial begin
    vec_t v;
    int relCnt[15];
    logic [4:0] we;
    logic [2:0] clr;

    compared   = 0;
    mismatched = 0;
`ifdef PIPE_CTRL_STALL_CNT_EN
    expStall   = 0;
`endif

    // Sequential table, starting from a freshly reset block (count 0).
    tbl[0]  = mkVec("idle",          0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[1]  = mkVec("load_use",      1,0,0,0,0,0, WE_STALL, CLR_STALL, 2'b00, 4'd0);
    tbl[2]  = mkVec("after_ld_use",  0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[3]  = mkVec("use_idle_mdu",  0,0,0,1,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[4]  = mkVec("eret_vs_stall", 1,0,0,0,0,1, WE_ALL,   CLR_ERET,  2'b10, 4'd0);
    tbl[5]  = mkVec("exc_st_stall",  1,1,0,0,1,0, WE_ALL,   CLR_EXC,   2'b01, 4'd0);
    tbl[6]  = mkVec("exc_and_eret",  0,0,0,0,1,1, WE_ALL,   CLR_EXC,   2'b01, 4'd0);
    tbl[7]  = mkVec("no_start_exc",  0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[8]  = mkVec("mult_start",    0,1,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[9]  = mkVec("busy_no_use",   0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd5);
    tbl[10] = mkVec("busy_use",      0,0,0,1,0,0, WE_STALL, CLR_STALL, 2'b00, 4'd4);
    tbl[11] = mkVec("busy_exc",      0,0,0,1,1,0, WE_ALL,   CLR_EXC,   2'b01, 4'd3);
    tbl[12] = mkVec("busy_eret",     0,0,0,1,0,1, WE_ALL,   CLR_ERET,  2'b10, 4'd2);
    tbl[13] = mkVec("busy_last",     0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd1);
    tbl[14] = mkVec("busy_done",     0,0,0,0,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);
    tbl[15] = mkVec("use_after",     0,0,0,1,0,0, WE_ALL,   CLR_NONE,  2'b00, 4'd0);

    // Reset state, asserted before the first edge.
    reset = 1'b0;
    #3;
    applyStimulus(mkVec("reset", 0,0,0,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd0));
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) runCycle(tbl[i]);

    // mult followed by an MDU user held in D: 6 stall cycles, then advance.
    for (int k = 0; k < 7; k++) begin
      we  = (k <= 5) ? WE_STALL : WE_ALL;
      clr = (k <= 5) ? CLR_STALL : CLR_NONE;
      runCycle(mkVec("mult_mfhi", 0, (k == 0), 0, 1, 0, 0, we, clr, 2'b00,
                     (k == 0) ? 4'd0 : 4'(6 - k)));
    end

    // A div start while a mult countdown runs reloads the count.
    relCnt = '{0, 5, 4, 3, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    for (int k = 0; k < 15; k++) begin
      runCycle(mkVec("reload", 0, (k == 0 || k == 3), (k == 3), 0, 0, 0,
                     WE_ALL, CLR_NONE, 2'b00, 4'(relCnt[k])));
    end

    // Exception at md_count = 4 must not stop the div countdown.
    for (int k = 0; k < 12; k++) begin
      runCycle(mkVec("div_exc", 0, (k == 0), (k == 0), 0, (k == 7), 0,
                     WE_ALL, (k == 7) ? CLR_EXC : CLR_NONE,
                     (k == 7) ? 2'b01 : 2'b00,
                     (k == 0) ? 4'd0 : 4'(11 - k)));
    end

    // Asynchronous reset in the middle of a div countdown.
    for (int k = 0; k < 4; k++) begin
      runCycle(mkVec("rst_pre", 0, (k == 0), (k == 0), 0, 0, 0,
                     WE_ALL, CLR_NONE, 2'b00, (k == 0) ? 4'd0 : 4'(11 - k)));
    end
    applyStimulus(mkVec("rst_cnt7", 0,0,0,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd7));
    #1;
    checkOutput();
    reset = 1'b0;
`ifdef PIPE_CTRL_STALL_CNT_EN
    expStall = 0;
`endif
    #1;
    applyStimulus(mkVec("rst_async", 0,0,0,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd0));
    checkOutput();
    // No start is accepted while reset is held across an edge.
    applyStimulus(mkVec("rst_hold_st", 0,1,1,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd0));
    @(posedge clk);
    #2;
    checkOutput();
    applyStimulus(mkVec("rst_hold_idle", 0,0,0,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd0));
    checkOutput();
    reset = 1'b1;
    runCycle(mkVec("post_rst_st", 0,1,0,0,0,0, WE_ALL, CLR_NONE, 2'b00, 4'd0));
    runCycle(mkVec("post_rst_busy", 0,0,0,1,0,0, WE_STALL, CLR_STALL, 2'b00, 4'd5));
    runCycle(mkVec("post_rst_eret", 1,0,0,1,0,1, WE_ALL, CLR_ERET, 2'b10, 4'd4));

    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d records left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
